// File: rtl/ltssm_tsos_rx.sv
// ltssm_tsos_rx
//   Per-lane receive parser for PCIe Gen1/2 TS1/TS2 training ordered sets.
//   Consumes the 32-bit ordered-set stream (4 symbols per beat, 4 beats per
//   TS), decodes link/lane/N_FTS/rate/training-control, pulses a valid for
//   each well-formed TS1 or TS2, flags malformed ordered sets, and counts
//   consecutive identical TSs (saturating at 255).
//
// Ports
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   s_axis_t*_i           ordered-set stream; tuser[0] marks an OS beat
//   s_axis_tready_o       1 whenever out of reset
//   clear_i               zero the consecutive-TS counter
//   ts1_valid_o           one-cycle pulse per committed TS1
//   ts2_valid_o           one-cycle pulse per committed TS2
//   link_num_o..          fields of the last committed TS (held otherwise)
//   training_ctrl_o
//   consec_cnt_o          consecutive identical TS count
//   error_o               one-cycle pulse per malformed ordered set

package ltssm_tsos_rx_pkg;
    typedef struct packed {
        logic [2:0] rsvd;
        logic       os_beat;
    } phy_user_t;

    typedef struct packed {
        logic [2:0] rsvd;
        logic       compliance_rx;
        logic       scramble_dis;
        logic       loopback;
        logic       link_dis;
        logic       hot_reset;
    } training_ctrl_t;
endpackage

module ltssm_tsos_rx
    import ltssm_tsos_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = $bits(phy_user_t)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_i,
    input  logic                  s_axis_tvalid_i,
    input  logic                  s_axis_tlast_i,
    input  logic [USER_WIDTH-1:0] s_axis_tuser_i,
    output logic                  s_axis_tready_o,
    input  logic                  clear_i,
    output logic                  ts1_valid_o,
    output logic                  ts2_valid_o,
    output logic [7:0]            link_num_o,
    output logic [7:0]            lane_num_o,
    output logic [7:0]            n_fts_o,
    output logic [7:0]            rate_id_o,
    output training_ctrl_t        training_ctrl_o,
    output logic [7:0]            consec_cnt_o,
    output logic                  error_o
);

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] ID_TS1  = 8'h4A;
    localparam logic [7:0] ID_TS2  = 8'h45;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_B1,
        ST_B2,
        ST_B3,
        ST_DROP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [7:0] w_sym [4];
    logic       w_hs;
    logic       w_keep_ok;
    logic       w_os_beat;
    logic       w_beat_4a;
    logic       w_beat_45;
    logic       w_fin_4a;
    logic       w_fin_45;
    logic       w_cap0;
    logic       w_cap1;
    logic       w_cap2;
    logic       w_commit;
    logic       w_err;
    logic       w_same;
    logic       w_unused;

    // Capture registers for the TS in flight (data only, no reset needed)
    logic [7:0]     r_cap_link;
    logic [7:0]     r_cap_lane;
    logic [7:0]     r_cap_nfts;
    logic [7:0]     r_cap_rate;
    training_ctrl_t r_cap_ctrl;
    logic           r_all_4a;
    logic           r_all_45;

    // Registered outputs
    logic           r_ready;
    logic           r_ts1_valid;
    logic           r_ts2_valid;
    logic           r_error;
    logic [7:0]     r_link;
    logic [7:0]     r_lane;
    logic [7:0]     r_nfts;
    logic [7:0]     r_rate;
    training_ctrl_t r_ctrl;
    logic           r_last_ts2;
    logic [7:0]     r_cnt;

    // Only the OS-beat marker of tuser is meaningful here.
    assign w_unused  = ^s_axis_tuser_i;
    assign w_os_beat = s_axis_tuser_i[0];

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            w_sym[n] = s_axis_tdata_i[8*n +: 8];
        end
    end

    assign w_hs      = s_axis_tvalid_i & r_ready;
    assign w_keep_ok = &s_axis_tkeep_i;
    assign w_beat_4a = (w_sym[0] == ID_TS1) && (w_sym[1] == ID_TS1) &&
                       (w_sym[2] == ID_TS1) && (w_sym[3] == ID_TS1);
    assign w_beat_45 = (w_sym[0] == ID_TS2) && (w_sym[1] == ID_TS2) &&
                       (w_sym[2] == ID_TS2) && (w_sym[3] == ID_TS2);
    // Final identifier verdict, valid while the last beat is presented.
    assign w_fin_4a  = r_all_4a & w_beat_4a;
    assign w_fin_45  = r_all_45 & w_beat_45;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cap0      = 1'b0;
        w_cap1      = 1'b0;
        w_cap2      = 1'b0;
        w_commit    = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Non-OS beats are dropped silently without entering ST_DROP.
                if (w_hs && w_os_beat) begin
                    if ((w_sym[0] == SYM_COM) && w_keep_ok) begin
                        w_cap0      = 1'b1;
                        w_state_nxt = ST_B1;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = s_axis_tlast_i ? ST_IDLE : ST_DROP;
                    end
                end
            end
            ST_B1, ST_B2: begin
                if (w_hs) begin
                    if (s_axis_tlast_i || !w_keep_ok) begin
                        w_err       = 1'b1;
                        w_state_nxt = s_axis_tlast_i ? ST_IDLE : ST_DROP;
                    end else if (r_state == ST_B1) begin
                        w_cap1      = 1'b1;
                        w_state_nxt = ST_B2;
                    end else begin
                        w_cap2      = 1'b1;
                        w_state_nxt = ST_B3;
                    end
                end
            end
            ST_B3: begin
                if (w_hs) begin
                    if (s_axis_tlast_i && w_keep_ok && (w_fin_4a || w_fin_45)) begin
                        w_commit    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = s_axis_tlast_i ? ST_IDLE : ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (w_hs && s_axis_tlast_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Beat 0 carries link/lane/N_FTS; beat 1 carries rate/ctrl and the first
    // two identifier symbols; beat 2 is all identifier.
    always_ff @(posedge clk_i) begin
        if (w_cap0) begin
            r_cap_link <= w_sym[1];
            r_cap_lane <= w_sym[2];
            r_cap_nfts <= w_sym[3];
        end
        if (w_cap1) begin
            r_cap_rate <= w_sym[0];
            r_cap_ctrl <= training_ctrl_t'(w_sym[1]);
            r_all_4a   <= (w_sym[2] == ID_TS1) && (w_sym[3] == ID_TS1);
            r_all_45   <= (w_sym[2] == ID_TS2) && (w_sym[3] == ID_TS2);
        end
        if (w_cap2) begin
            r_all_4a <= r_all_4a & w_beat_4a;
            r_all_45 <= r_all_45 & w_beat_45;
        end
    end

    // Candidate set identical to the previously committed one (type included).
    assign w_same = ({w_fin_45, r_cap_link, r_cap_lane, r_cap_nfts, r_cap_rate, r_cap_ctrl} ==
                     {r_last_ts2, r_link, r_lane, r_nfts, r_rate, r_ctrl});

    // ---- output stage: decisions registered one cycle after the deciding beat
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_ready     <= 1'b0;
            r_ts1_valid <= 1'b0;
            r_ts2_valid <= 1'b0;
            r_error     <= 1'b0;
            r_link      <= 8'd0;
            r_lane      <= 8'd0;
            r_nfts      <= 8'd0;
            r_rate      <= 8'd0;
            r_ctrl      <= '0;
            r_last_ts2  <= 1'b0;
            r_cnt       <= 8'd0;
        end else begin
            r_ready     <= 1'b1;
            r_ts1_valid <= w_commit & w_fin_4a;
            r_ts2_valid <= w_commit & ~w_fin_4a;
            r_error     <= w_err;
            if (w_commit) begin
                r_link     <= r_cap_link;
                r_lane     <= r_cap_lane;
                r_nfts     <= r_cap_nfts;
                r_rate     <= r_cap_rate;
                r_ctrl     <= r_cap_ctrl;
                r_last_ts2 <= ~w_fin_4a;
                // A clear on the commit cycle wins, so the new TS starts a run of 1.
                if (clear_i || !w_same || (r_cnt == 8'd0)) begin
                    r_cnt <= 8'd1;
                end else if (r_cnt != 8'hFF) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end else if (w_err || clear_i) begin
                r_cnt <= 8'd0;
            end
        end
    end

    assign s_axis_tready_o = r_ready;
    assign ts1_valid_o     = r_ts1_valid;
    assign ts2_valid_o     = r_ts2_valid;
    assign error_o         = r_error;
    assign link_num_o      = r_link;
    assign lane_num_o      = r_lane;
    assign n_fts_o         = r_nfts;
    assign rate_id_o       = r_rate;
    assign training_ctrl_o = r_ctrl;
    assign consec_cnt_o    = r_cnt;

endmodule

// File: tb/tb_ltssm_tsos_rx.sv
// tb_ltssm_tsos_rx
//   Scoreboard bench for ltssm_tsos_rx: every driven ordered set pushes its
//   expected outcome (valid/error pulse, fields, counter, output cycle) and
//   a negedge monitor pops and compares whenever the DUT pulses.

module tb_ltssm_tsos_rx;
    import ltssm_tsos_rx_pkg::*;

    localparam int UW = $bits(phy_user_t);

    logic           clk = 1'b0;
    logic           rst_n;
    logic [31:0]    tdata;
    logic [3:0]     tkeep;
    logic           tvalid;
    logic           tlast;
    logic [UW-1:0]  tuser;
    logic           tready;
    logic           clear;
    logic           ts1;
    logic           ts2;
    logic [7:0]     link;
    logic [7:0]     lane;
    logic [7:0]     nfts;
    logic [7:0]     rate;
    training_ctrl_t ctrl;
    logic [7:0]     cnt;
    logic           err;

    always #5 clk = ~clk;

    ltssm_tsos_rx dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .s_axis_tdata_i  (tdata),
        .s_axis_tkeep_i  (tkeep),
        .s_axis_tvalid_i (tvalid),
        .s_axis_tlast_i  (tlast),
        .s_axis_tuser_i  (tuser),
        .s_axis_tready_o (tready),
        .clear_i         (clear),
        .ts1_valid_o     (ts1),
        .ts2_valid_o     (ts2),
        .link_num_o      (link),
        .lane_num_o      (lane),
        .n_fts_o         (nfts),
        .rate_id_o       (rate),
        .training_ctrl_o (ctrl),
        .consec_cnt_o    (cnt),
        .error_o         (err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic       t1;
        logic       t2;
        logic       er;
        logic [7:0] link;
        logic [7:0] lane;
        logic [7:0] nfts;
        logic [7:0] rate;
        logic [7:0] ctrl;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    // Reference model of the committed state
    logic [7:0] m_link, m_lane, m_nfts, m_rate, m_ctrl, m_cnt;
    logic [1:0] m_type;
    int         last_cyc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && (ts1 || ts2 || err)) begin
            if (sb.size() == 0) begin
                check_val("unexpected_pulse", {29'd0, ts1, ts2, err}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("ts1_valid", 32'(ts1), 32'(e.t1));
                check_val("ts2_valid", 32'(ts2), 32'(e.t2));
                check_val("error",     32'(err), 32'(e.er));
                check_val("link",      32'(link), 32'(e.link));
                check_val("lane",      32'(lane), 32'(e.lane));
                check_val("n_fts",     32'(nfts), 32'(e.nfts));
                check_val("rate",      32'(rate), 32'(e.rate));
                check_val("ctrl",      32'(ctrl), 32'(e.ctrl));
                check_val("consec",    32'(cnt), 32'(e.cnt));
                check_val("out_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic model_reset();
        m_link = 8'd0; m_lane = 8'd0; m_nfts = 8'd0; m_rate = 8'd0; m_ctrl = 8'd0;
        m_cnt  = 8'd0; m_type = 2'd0;
    endtask

    task automatic exp_commit(input bit is1, input logic [7:0] l, input logic [7:0] ln,
                              input logic [7:0] nf, input logic [7:0] rt, input logic [7:0] ct,
                              input bit clr);
        exp_t e;
        bit   same;
        same = (m_type == (is1 ? 2'd1 : 2'd2)) && (l == m_link) && (ln == m_lane) &&
               (nf == m_nfts) && (rt == m_rate) && (ct == m_ctrl);
        if (clr || !same || m_cnt == 8'd0) m_cnt = 8'd1;
        else if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
        m_type = is1 ? 2'd1 : 2'd2;
        m_link = l; m_lane = ln; m_nfts = nf; m_rate = rt; m_ctrl = ct;
        e.t1 = is1; e.t2 = !is1; e.er = 1'b0;
        e.link = m_link; e.lane = m_lane; e.nfts = m_nfts; e.rate = m_rate; e.ctrl = m_ctrl;
        e.cnt = m_cnt; e.cyc = last_cyc + 1;
        sb.push_back(e);
    endtask

    task automatic exp_error();
        exp_t e;
        m_cnt = 8'd0;
        e.t1 = 1'b0; e.t2 = 1'b0; e.er = 1'b1;
        e.link = m_link; e.lane = m_lane; e.nfts = m_nfts; e.rate = m_rate; e.ctrl = m_ctrl;
        e.cnt = 8'd0; e.cyc = last_cyc + 1;
        sb.push_back(e);
    endtask

    function automatic logic [127:0] mk_ts(input bit is1, input logic [7:0] l, input logic [7:0] ln,
                                           input logic [7:0] nf, input logic [7:0] rt,
                                           input logic [7:0] ct);
        logic [127:0] p;
        p[7:0]   = 8'hBC;
        p[15:8]  = l;
        p[23:16] = ln;
        p[31:24] = nf;
        p[39:32] = rt;
        p[47:40] = ct;
        for (int i = 6; i < 16; i++) p[8*i +: 8] = is1 ? 8'h4A : 8'h45;
        return p;
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic l, input logic u,
                             input logic [3:0] kp, input logic c);
        @(negedge clk);
        tdata    = d;
        tlast    = l;
        tuser    = '0;
        tuser[0] = u;
        tkeep    = kp;
        tvalid   = 1'b1;
        clear    = c;
        last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            tvalid = 1'b0;
            clear  = 1'b0;
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        tvalid = 1'b0;
        clear  = 1'b1;
        @(negedge clk);
        clear  = 1'b0;
        m_cnt  = 8'd0;
    endtask

    task automatic send_pkt(input logic [127:0] p, input logic [3:0] lastm, input int nb,
                            input int bad_keep, input int gap_max, input bit clr_last);
        for (int k = 0; k < nb; k++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin
                @(negedge clk);
                tvalid = 1'b0;
                clear  = 1'b0;
                tdata  = $urandom;
                tlast  = 1'($urandom);
            end
            send_beat(p[32*k +: 32], lastm[k], 1'b1, (k == bad_keep) ? 4'b0111 : 4'hF,
                      clr_last && (k == nb - 1));
        end
    endtask

    task automatic send_ts(input bit is1, input logic [7:0] l, input logic [7:0] ln,
                           input logic [7:0] nf, input logic [7:0] rt, input logic [7:0] ct,
                           input int gap_max, input bit clr);
        send_pkt(mk_ts(is1, l, ln, nf, rt, ct), 4'b1000, 4, -1, gap_max, clr);
        exp_commit(is1, l, ln, nf, rt, ct, clr);
    endtask

    initial begin
        logic [127:0] p;
        rst_n  = 1'b0;
        tvalid = 1'b0;
        tdata  = '0;
        tkeep  = 4'hF;
        tlast  = 1'b0;
        tuser  = '0;
        clear  = 1'b0;
        last_cyc = 0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_tready", 32'(tready), 32'd0);
        check_val("rst_ts1",    32'(ts1), 32'd0);
        check_val("rst_ts2",    32'(ts2), 32'd0);
        check_val("rst_err",    32'(err), 32'd0);
        check_val("rst_link",   32'(link), 32'd0);
        check_val("rst_cnt",    32'(cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("tready_up", 32'(tready), 32'd1);

        // 8 back-to-back TS1 with PAD link/lane
        for (int i = 0; i < 8; i++) send_ts(1'b1, 8'hF7, 8'hF7, 8'h20, 8'h02, 8'h00, 0, 1'b0);
        idle(3);

        // TS1 x3 then TS2 with identical fields
        pulse_clear();
        for (int i = 0; i < 3; i++) send_ts(1'b1, 8'h01, 8'h00, 8'h80, 8'h02, 8'h00, 0, 1'b0);
        send_ts(1'b0, 8'h01, 8'h00, 8'h80, 8'h02, 8'h00, 0, 1'b0);
        idle(2);

        // Corrupt identifier symbol 10
        p = mk_ts(1'b1, 8'h01, 8'h00, 8'h80, 8'h02, 8'h00);
        p[87:80] = 8'h45;
        send_pkt(p, 4'b1000, 4, -1, 0, 1'b0);
        exp_error();
        idle(2);

        // tlast on beat 1, then an immediate good TS2
        send_pkt(mk_ts(1'b1, 8'h01, 8'h00, 8'h80, 8'h02, 8'h00), 4'b0010, 2, -1, 0, 1'b0);
        exp_error();
        send_ts(1'b0, 8'h02, 8'h01, 8'h40, 8'h01, 8'h08, 0, 1'b0);
        idle(2);

        // Beat 3 missing tlast, two junk beats, then a good TS1
        send_pkt(mk_ts(1'b1, 8'h02, 8'h01, 8'h40, 8'h01, 8'h08), 4'b0000, 4, -1, 0, 1'b0);
        exp_error();
        send_beat(32'hBCBCBCBC, 1'b0, 1'b1, 4'hF, 1'b0);
        send_beat(32'h12345678, 1'b1, 1'b1, 4'hF, 1'b0);
        send_ts(1'b1, 8'h02, 8'h01, 8'h40, 8'h01, 8'h08, 0, 1'b0);
        idle(2);

        // Idle-state handling: non-OS beat ignored, bad COM / bad keep flagged
        send_beat(32'h000000BC, 1'b1, 1'b0, 4'hF, 1'b0);
        send_beat(32'h11223344, 1'b1, 1'b1, 4'hF, 1'b0);
        exp_error();
        send_beat(32'h000000BC, 1'b0, 1'b1, 4'b0111, 1'b0);
        exp_error();
        send_beat(32'hA5A5A5A5, 1'b1, 1'b1, 4'hF, 1'b0);
        send_ts(1'b0, 8'h02, 8'h01, 8'h40, 8'h01, 8'h08, 0, 1'b0);
        send_pkt(mk_ts(1'b0, 8'h02, 8'h01, 8'h40, 8'h01, 8'h08), 4'b0000, 3, 2, 0, 1'b0);
        exp_error();
        send_beat(32'h5A5A5A5A, 1'b1, 1'b1, 4'hF, 1'b0);
        send_ts(1'b0, 8'h02, 8'h01, 8'h40, 8'h01, 8'h08, 0, 1'b0);
        idle(2);

        // Random tvalid gaps, clear coincident with commit, standalone clear
        for (int i = 0; i < 4; i++) send_ts(1'b0, 8'h03, 8'h02, 8'hFF, 8'h02, 8'h01, 3, 1'b0);
        send_ts(1'b0, 8'h03, 8'h02, 8'hFF, 8'h02, 8'h01, 3, 1'b1);
        idle(1);
        send_ts(1'b0, 8'h03, 8'h02, 8'hFF, 8'h02, 8'h01, 2, 1'b0);
        pulse_clear();
        send_ts(1'b0, 8'h03, 8'h02, 8'hFF, 8'h02, 8'h01, 0, 1'b0);
        idle(2);

        // Counter saturation at 255
        pulse_clear();
        for (int i = 0; i < 258; i++) send_ts(1'b1, 8'hF7, 8'hF7, 8'h20, 8'h02, 8'h00, 0, 1'b0);
        idle(3);

        // Reset in the middle of a TS aborts it silently
        send_pkt(mk_ts(1'b1, 8'h09, 8'h09, 8'h09, 8'h01, 8'h00), 4'b1000, 2, -1, 0, 1'b0);
        @(negedge clk);
        rst_n  = 1'b0;
        tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check_val("mid_rst_tready", 32'(tready), 32'd1);
        check_val("mid_rst_link",   32'(link), 32'd0);
        check_val("mid_rst_cnt",    32'(cnt), 32'd0);
        send_ts(1'b1, 8'h05, 8'h06, 8'h07, 8'h01, 8'h00, 0, 1'b0);
        idle(4);

        check_val("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ltssm_tsos_rx.md
# ltssm_tsos_rx

Per-lane receive-side parser for PCIe Gen1/2 training ordered sets (TS1/TS2). It consumes the 32-bit AXI-Stream ordered-set stream from the lane's symbol-alignment/descrambler path and decodes the link number, lane number, N_FTS, rate ID and training control fields. It pulses `ts1_valid_o` / `ts2_valid_o` and tracks a consecutive-identical-TS count. The polling and configuration LTSSM sub-state blocks consume one instance per lane.

## Interface
- `DATA_WIDTH`, 32: stream data width; fixed at 32, 4 symbols per beat.
- `KEEP_WIDTH`, `DATA_WIDTH/8`: tkeep width.
- `USER_WIDTH`, `$bits(phy_user_t)`: tuser width; bit 0 = ordered-set beat marker.

- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `s_axis_tdata_i`  in  32  symbols; symbol n of beat in `[8n+:8]`.
- `s_axis_tkeep_i`  in  4  byte enables; all ones is required.
- `s_axis_tvalid_i`  in  1  beat valid.
- `s_axis_tlast_i`  in  1  last beat of ordered set.
- `s_axis_tuser_i`  in  USER_WIDTH  bit 0 = ordered-set beat.
- `s_axis_tready_o`  out  1  always 1 out of reset.
- `clear_i`  in  1  zero the consecutive counter.
- `ts1_valid_o`  out  1  one-cycle pulse: valid TS1 received.
- `ts2_valid_o`  out  1  one-cycle pulse: valid TS2 received.
- `link_num_o`  out  8  symbol 1 of last valid TS.
- `lane_num_o`  out  8  symbol 2.
- `n_fts_o`  out  8  symbol 3.
- `rate_id_o`  out  8  symbol 4.
- `training_ctrl_o`  out  `training_ctrl_t`  symbol 5.
- `consec_cnt_o`  out  8  count of consecutive identical valid TSs, saturating at 255.
- `error_o`  out  1  one-cycle pulse on a malformed ordered set.

## Operation
- TS format: 16 symbols in 4 beats, beat k holding symbols 4k..4k+3.
  - Sym0 = COM `8'hBC`; sym1–5 = fields; sym6–15 = identifier.
  - Identifier is `8'h4A` for TS1 and `8'h45` for TS2.
  - `tlast` is set on beat 3 only.
- FSM states: ST_IDLE, ST_B1, ST_B2, ST_B3, ST_DROP. Transitions occur only on a handshake (`tvalid & tready`); gaps in tvalid hold state.
- ST_IDLE:
  - Beat with `tuser[0]=0`: discarded silently, no error.
  - Beat with `tuser[0]=1` and sym0=COM and tkeep all ones: capture sym1–3, go ST_B1.
  - Otherwise: pulse error, go ST_DROP; if tlast is set on that beat, stay in ST_IDLE instead.
- ST_B1: capture sym4, sym5 and begin identifier checking.
  - Two flags accumulate per beat: `all_4a` and `all_45`.
  - Each is the AND of all identifier bytes seen so far against the TS1 or TS2 value.
- ST_B1, ST_B2: tlast set, or tkeep not all ones → pulse error, go ST_IDLE (or ST_DROP if tlast was clear).
- ST_B3: the beat must carry tlast, tkeep all ones, and a final `all_4a` or `all_45`.
  - If so, commit: latch the fields, pulse the matching valid, go ST_IDLE.
  - Otherwise pulse error; go ST_IDLE if tlast is set, else ST_DROP.
- ST_DROP: discard beats until a beat with tlast, then go ST_IDLE. No further error pulses while dropping.
- Field outputs change only on commit and hold their value otherwise.
- Consecutive counter:
  - On commit: if {type, link, lane, n_fts, rate, ctrl} equals the previous committed set and the counter is nonzero, increment (saturate at 255); otherwise load 1.
  - Any error pulse zeros the counter.
  - `clear_i` zeros the counter. On the same cycle as a commit, clear applies first, so the result is 1.
- Link/lane PAD (`8'hF7`) values are passed through undecoded; the consumer checks for PAD.

## Timing
- Reset values: tready=0 during reset; all valid/error pulses 0; fields 0; counter 0; FSM in ST_IDLE.
- `s_axis_tready_o`=1 from the first cycle after reset deasserts.
- Latency: valid, error, fields and counter are registered and appear the cycle after the handshake on the deciding beat.
- Throughput: back-to-back TSs with no idle cycles are sustained, one TS per 4 cycles.
- Reset asserted mid-ordered-set aborts it with no pulse. The first beat after reset is parsed as ST_IDLE.

## Test plan
- Reset, then 8 back-to-back TS1 beats with link=lane=`F7`, n_fts=`8'h20`, rate=`8'h02`, ctrl=0 → 8 `ts1_valid_o` pulses spaced 4 cycles apart, `consec_cnt_o` 1..8, `link_num_o`=`F7`, `error_o` never asserts.
- TS1 ×3 then TS2 with identical fields → third pulse shows cnt=3; the TS2 gives a `ts2_valid_o` pulse with cnt=1.
- TS1 with sym10=`8'h45` → `error_o` pulse one cycle after beat 3, no valid pulse, cnt=0, fields keep their prior values.
- `tlast` on beat 1 → error pulse, FSM returns to ST_IDLE; an immediately following good TS2 → `ts2_valid_o`, cnt=1.
- Beat 3 missing tlast, followed by 2 junk beats, the second with tlast, then a good TS1 → exactly one error pulse, then one `ts1_valid_o`.
- Random tvalid gaps inside a TS; `clear_i` coincident with commit → valid still pulses, cnt=1; reset mid-TS → no pulse, next TS decodes correctly.
